// File: rtl/fft_reorder_8_if.sv
// Sample bus of the FFT output reorder block: bit-reversed input side and
// natural-order output side.
interface fft_reorder_8_if #(
    parameter int DBW = 8,
    parameter int CBW = 3
);
    logic               clear;
    logic               sof;
    logic [2*DBW-1:0]   din;
    logic [2*DBW-1:0]   dout;
    logic               dout_valid;
    logic [CBW-1:0]     dout_idx;
    logic               dout_sof;
    logic               sync_err;

    modport master (
        output clear, sof, din,
        input  dout, dout_valid, dout_idx, dout_sof, sync_err
    );

    modport slave (
        input  clear, sof, din,
        output dout, dout_valid, dout_idx, dout_sof, sync_err
    );
endinterface

// File: rtl/fft_reorder_8.sv
// Ping-pong reorder buffer: writes FFT samples at bit-reversed addresses and
// streams each completed bank out in natural bin order.
module fft_reorder_8 #(
    parameter int DBW = 8,
    parameter int CBW = 3
) (
    input  logic             clk,
    input  logic             rstx,
    fft_reorder_8_if.slave   bus
);
    localparam int N = 2**CBW;
    localparam logic [CBW-1:0] LAST = '1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM} state_t;

    state_t           state;
    logic [CBW-1:0]   wcnt;
    logic             wsel;
    logic [CBW-1:0]   rptr;
    logic             rd_go;
    logic             rd_busy;

    logic [2*DBW-1:0] mem [2*N];
    logic             we;
    logic [CBW-1:0]   waddr;
    logic [CBW-1:0]   raddr;
    logic [2*DBW-1:0] rd_data;

    function automatic logic [CBW-1:0] bitrev(input logic [CBW-1:0] k);
        return {<<{k}};
    endfunction

    assign we      = !bus.clear && (bus.sof || state != S_IDLE);
    assign waddr   = bus.sof ? '0 : bitrev(wcnt);
    // A freshly completed bank always starts reading at bin 0.
    assign raddr   = rd_go ? '0 : rptr;
    assign rd_data = mem[{~wsel, raddr}];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wsel, waddr}] <= bus.din;
        end
    end

    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            wsel           <= 1'b0;
            rptr           <= '0;
            rd_go          <= 1'b0;
            rd_busy        <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_idx   <= '0;
            bus.dout_sof   <= 1'b0;
            bus.sync_err   <= 1'b0;
        end else if (bus.clear) begin
            state          <= S_IDLE;
            wcnt           <= '0;
            wsel           <= 1'b0;
            rptr           <= '0;
            rd_go          <= 1'b0;
            rd_busy        <= 1'b0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.dout_idx   <= '0;
            bus.dout_sof   <= 1'b0;
            bus.sync_err   <= 1'b0;
        end else begin
            rd_go        <= 1'b0;
            bus.sync_err <= 1'b0;

            // sof restarts the frame in the current bank; wsel is left alone
            if (bus.sof) begin
                wcnt <= CBW'(1);
                if (state == S_IDLE) begin
                    state <= S_FILL;
                end
                if (wcnt != '0) begin
                    bus.sync_err <= 1'b1;
                end
            end else if (state != S_IDLE) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == LAST) begin
                    wsel  <= ~wsel;
                    rd_go <= 1'b1;
                    state <= S_STREAM;
                end
            end

            if (rd_go || rd_busy) begin
                bus.dout       <= rd_data;
                bus.dout_idx   <= raddr;
                bus.dout_valid <= 1'b1;
                bus.dout_sof   <= (raddr == '0);
                rptr           <= raddr + 1'b1;
                rd_busy        <= (raddr != LAST);
            end else begin
                bus.dout_valid <= 1'b0;
                bus.dout_sof   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_reorder_8.sv
// Self-checking bench for fft_reorder_8 against a frame-level reference model.
module tb_fft_reorder_8;
    localparam int DBW = 8;
    localparam int CBW = 3;
    localparam int N   = 2**CBW;

    logic clk  = 1'b0;
    logic rstx = 1'b0;
    always #5 clk = ~clk;

    fft_reorder_8_if #(.DBW(DBW), .CBW(CBW)) bus ();
    fft_reorder_8 #(.DBW(DBW), .CBW(CBW)) dut (.clk(clk), .rstx(rstx), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Reference model: the frame is collected in natural order, and on
    // completion its bins are scheduled for output on the following cycles.
    logic [2*DBW-1:0] frame [N];
    int               pos;
    bit               active;
    logic [2*DBW-1:0] sched_d [int];
    int               sched_i [int];
    bit               dout_known;
    bit               exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < CBW; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

    task automatic model_reset();
        sched_d.delete();
        sched_i.delete();
        active     = 1'b0;
        pos        = 0;
        dout_known = 1'b1;
    endtask

    task automatic step(input bit s, input logic [2*DBW-1:0] d, input bit c);
        bus.sof   = s;
        bus.din   = d;
        bus.clear = c;
        @(posedge clk);
        exp_err = 1'b0;
        if (c) begin
            model_reset();
        end else if (s) begin
            exp_err  = active && (pos != 0);
            active   = 1'b1;
            frame[0] = d;
            pos      = 1;
        end else if (active) begin
            frame[brev(pos)] = d;
            pos++;
            if (pos == N) begin
                for (int k = 0; k < N; k++) begin
                    sched_d[cyc + 1 + k] = frame[k];
                    sched_i[cyc + 1 + k] = k;
                end
                pos = 0;
            end
        end
        #1;
        check("sync_err", bus.sync_err, exp_err);
        if (sched_d.exists(cyc)) begin
            check("valid", bus.dout_valid, 1);
            check("dout", bus.dout, sched_d[cyc]);
            check("idx", bus.dout_idx, sched_i[cyc]);
            check("dout_sof", bus.dout_sof, sched_i[cyc] == 0);
            dout_known = 1'b0;
            sched_d.delete(cyc);
            sched_i.delete(cyc);
        end else begin
            check("valid_idle", bus.dout_valid, 0);
            check("sof_idle", bus.dout_sof, 0);
            if (dout_known) begin
                check("dout_zero", bus.dout, 0);
                check("idx_zero", bus.dout_idx, 0);
            end
        end
        cyc++;
    endtask

    function automatic logic [2*DBW-1:0] rnd();
        return (2*DBW)'($urandom);
    endfunction

    initial begin
        bus.sof   = 1'b0;
        bus.din   = '0;
        bus.clear = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", bus.dout, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_idx", bus.dout_idx, 0);
        check("rst_sof", bus.dout_sof, 0);
        check("rst_err", bus.sync_err, 0);
        rstx = 1'b1;

        repeat (3) step(1'b0, rnd(), 1'b0);

        // single frame: bit-reversed ramp comes out as a natural ramp
        for (int j = 0; j < N; j++) step(j == 0, (2*DBW)'(brev(j)), 1'b0);
        repeat (12) step(1'b0, rnd(), 1'b0);
        step(1'b0, rnd(), 1'b1);

        // four back-to-back frames with per-frame offset
        for (int j = 0; j < 4*N; j++) step(j == 0, (2*DBW)'(16*(j/N) + brev(j%N)), 1'b0);
        repeat (10) step(1'b0, rnd(), 1'b0);
        step(1'b0, rnd(), 1'b1);

        // mid-frame resync
        for (int j = 0; j < 16; j++) step(j == 0 || j == 3, rnd(), 1'b0);
        repeat (10) step(1'b0, rnd(), 1'b0);
        step(1'b0, rnd(), 1'b1);

        // clear during STREAM, then stay idle
        for (int j = 0; j < 10; j++) step(j == 0, rnd(), 1'b0);
        step(1'b0, rnd(), 1'b1);
        repeat (20) step(1'b0, rnd(), 1'b0);

        // asynchronous reset mid-STREAM
        for (int j = 0; j < 12; j++) step(j == 0, rnd(), 1'b0);
        #2 rstx = 1'b0;
        #1;
        check("arst_dout", bus.dout, 0);
        check("arst_valid", bus.dout_valid, 0);
        check("arst_idx", bus.dout_idx, 0);
        check("arst_sof", bus.dout_sof, 0);
        #1 rstx = 1'b1;
        model_reset();
        repeat (12) step(1'b0, rnd(), 1'b0);

        // clear and sof together, then sof one cycle later
        step(1'b1, rnd(), 1'b1);
        step(1'b1, rnd(), 1'b0);
        repeat (12) step(1'b0, rnd(), 1'b0);
        step(1'b0, rnd(), 1'b1);

        // random soak: misaligned and aligned sofs, occasional clears
        for (int j = 0; j < 400; j++) begin
            bit s;
            bit c;
            s = ($urandom_range(0, 15) == 0)
                || (!active && $urandom_range(0, 3) == 0)
                || (active && pos == 0 && $urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 63) == 0);
            step(s, rnd(), c);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_reorder_8.md
FFT_REORDER_8 -- requirements
Module: fft_reorder_8

Interface
REQ-001 Parameter DBW, default 8: bit width of each real and imaginary component.
REQ-002 Parameter CBW, default 3: frame index width; frame length N = 2**CBW.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstx  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 clear  input  1  synchronous restart; returns the block to IDLE.
REQ-006 sof  input  1  marks the din sample carrying bit-reversed index 0 of a frame.
REQ-007 din  input  2*DBW  FFT output sample in bit-reversed order; {imag, real}, one sample per cycle.
REQ-008 dout  output  2*DBW  reordered sample in natural bin order; {imag, real}, registered.
REQ-009 dout_valid  output  1  dout holds a valid bin.
REQ-010 dout_idx  output  CBW  natural bin index of dout.
REQ-011 dout_sof  output  1  high with dout_valid when dout_idx == 0.
REQ-012 sync_err  output  1  one-cycle pulse on a sof arriving mid-frame.

Function
REQ-013 Storage: two banks of N words x 2*DBW bits (ping-pong); wsel selects the write bank, and the read bank is ~wsel.
REQ-014 States: IDLE, FILL (first frame being written), STREAM (reading a completed bank).
REQ-015 IDLE: no writes, outputs hold their reset values, and the block waits for sof.
REQ-016 sof in any state: din is written to address 0 of bank wsel, and the write counter wcnt becomes 1.
REQ-017 sof in IDLE: the block enters FILL.
REQ-018 Each later cycle without sof: din is written to address bitrev(wcnt) of bank wsel, and wcnt increments modulo N.
REQ-019 Write of wcnt == N-1: marks the bank complete, toggles wsel on the same edge, and moves FILL to STREAM.
REQ-020 After the first sof, writing is free-running; no further sof is required for later frames.
REQ-021 Read: the edge after a bank completes loads dout from read-bank address 0; each following edge loads address r+1.
REQ-022 Read: dout_idx = r and dout_valid = 1 during the read; dout_sof = 1 when r == 0.
REQ-023 Read-to-write handover: a continuous input stream gives back-to-back frames with no bubble, and reading of bank B finishes on the same edge that completes the other bank.
REQ-024 Latency: bit-reversed index 0 captured at edge E0 gives natural bin 0 on dout after edge E0+N, and bin k after edge E0+N+k.
REQ-025 bitrev(k) reverses the CBW bits of k; with CBW=3, the map is 0,4,2,6,1,5,3,7.
REQ-026 sof with wcnt != 0 (mid-frame resync): the partial frame in bank wsel is abandoned, wsel is not toggled, and writing restarts at address 0 per REQ-016.
REQ-027 Mid-frame resync: sync_err pulses for 1 cycle, and a read already in progress from the other bank completes unaffected.
REQ-028 sof while wcnt == 0 (aligned): accepted silently, with no sync_err.
REQ-029 clear and sof in the same cycle: clear wins; the state is IDLE and the sample is not written.
REQ-030 clear: wcnt, wsel, state, and all outputs return to reset values on the next edge; bank contents need not be cleared.
REQ-031 Data path: no arithmetic; din is stored and reproduced bit-exact.

Reset
REQ-032 On rstx low, asynchronously: state = IDLE, wcnt = 0, wsel = 0, read pointer = 0.
REQ-033 On rstx low, asynchronously: dout = 0, dout_valid = 0, dout_idx = 0, dout_sof = 0, sync_err = 0.
REQ-034 Release of rstx takes effect on the first following rising edge; banks are undefined after reset and never read before being written.

Verification
REQ-035 Single frame, DBW=8, CBW=3: sof at E0 with din = 16'h0000,0004,0002,0006,0001,0005,0003,0007 (bit-reversed ramp) -> after edges E0+8..E0+15, dout = 0..7, dout_idx = 0..7, and dout_sof high only at E0+8.
REQ-036 Continuous 4 frames with frame f ramp offset 16*f -> dout_valid stays high with no gaps from E0+8 for 32 cycles, and the bins are natural-ordered per frame.
REQ-037 Resync: sof again at E0+3 -> sync_err = 1 for one cycle, no output from the abandoned frame, and the first dout_valid at E0+3+8.
REQ-038 clear asserted at E0+10 during STREAM -> after the next edge, dout_valid = 0 and dout = 0; with no new sof, output stays idle for 20 cycles.
REQ-039 rstx pulsed low between edges mid-STREAM -> outputs go to 0 immediately without a clock, and the block waits in IDLE for the next sof.
REQ-040 clear and sof in the same cycle -> no write occurs and the state stays IDLE; a sof one cycle later is accepted with latency per REQ-024.
